// File: rtl/systolic_ctrl.sv
// systolic_ctrl: clear/feed/drain/output sequencer for an NxN systolic MAC grid.
// Optional SYSTOLIC_CTRL_ABORT_EN adds abort_i, which returns any active run to IDLE.
module systolic_ctrl #(
  parameter int ARRAY_SIZE = 4,
  parameter int K_WIDTH    = 8,
  parameter int CNT_WIDTH  = K_WIDTH + $clog2(ARRAY_SIZE) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic [K_WIDTH-1:0]            k_i,
`ifdef SYSTOLIC_CTRL_ABORT_EN
  input  logic                          abort_i,
`endif
  output logic                          busy_o,
  output logic                          acc_clr_o,
  output logic [CNT_WIDTH-1:0]          feed_cnt_o,
  output logic [ARRAY_SIZE-1:0]         a_feed_o,
  output logic [ARRAY_SIZE-1:0]         b_feed_o,
  output logic                          res_valid_o,
  output logic [$clog2(ARRAY_SIZE)-1:0] res_row_o,
  input  logic                          res_ready_i,
  output logic                          done_o
);
  localparam int RW = $clog2(ARRAY_SIZE);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, OUTPUT, DONE} state_t;
  state_t               state;
  logic [K_WIDTH-1:0]   k_q;
  logic [RW-1:0]        drain_cnt;
  logic [CNT_WIDTH-1:0] last_t;
  logic                 abort;
`ifdef SYSTOLIC_CTRL_ABORT_EN
  assign abort = abort_i && state != IDLE || abort_i && start_i;
`else
  assign abort = 1'b0;
`endif
  assign last_t   = CNT_WIDTH'(k_q) + CNT_WIDTH'(ARRAY_SIZE - 2);
  assign b_feed_o = a_feed_o;
  // Lane r is live while operand index t-r lies in [0, k).
  function automatic logic [ARRAY_SIZE-1:0] feed_mask(input logic [CNT_WIDTH-1:0] t, input logic [K_WIDTH-1:0] k);
    logic [CNT_WIDTH:0] r_w;
    feed_mask = '0;
    for (int r = 0; r < ARRAY_SIZE; r++) begin
      r_w = (CNT_WIDTH+1)'(r);
      feed_mask[r] = ({1'b0, t} >= r_w) && ({1'b0, t} < r_w + (CNT_WIDTH+1)'(k));
    end
  endfunction
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state       <= IDLE;
      k_q         <= '0;
      drain_cnt   <= '0;
      busy_o      <= 1'b0;
      acc_clr_o   <= 1'b0;
      feed_cnt_o  <= '0;
      a_feed_o    <= '0;
      res_valid_o <= 1'b0;
      res_row_o   <= '0;
      done_o      <= 1'b0;
    end else begin
      acc_clr_o <= 1'b0;
      done_o    <= 1'b0;
      case (state)
        IDLE: if (start_i && k_i != '0) begin
          k_q       <= k_i;
          busy_o    <= 1'b1;
          acc_clr_o <= 1'b1;
          state     <= CLEAR;
        end
        CLEAR: begin
          state      <= FEED;
          feed_cnt_o <= '0;
          a_feed_o   <= feed_mask('0, k_q);
        end
        FEED: if (feed_cnt_o == last_t) begin
          state      <= DRAIN;
          feed_cnt_o <= '0;
          a_feed_o   <= '0;
          drain_cnt  <= '0;
        end else begin
          feed_cnt_o <= feed_cnt_o + CNT_WIDTH'(1);
          a_feed_o   <= feed_mask(feed_cnt_o + CNT_WIDTH'(1), k_q);
        end
        DRAIN: if (drain_cnt == RW'(ARRAY_SIZE - 1)) begin
          state       <= OUTPUT;
          res_valid_o <= 1'b1;
          res_row_o   <= '0;
        end else begin
          drain_cnt <= drain_cnt + RW'(1);
        end
        OUTPUT: if (res_ready_i) begin
          if (res_row_o == RW'(ARRAY_SIZE - 1)) begin
            state       <= DONE;
            res_valid_o <= 1'b0;
            res_row_o   <= '0;
            done_o      <= 1'b1;
          end else begin
            res_row_o <= res_row_o + RW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: scoreboard bench; driver queues expected per-cycle outputs, monitor pops on activity.
module tb_systolic_ctrl;
  localparam int N = 4;
  localparam int KW = 8;
  localparam int CW = KW + $clog2(N) + 1;
  typedef struct packed {
    logic          busy;
    logic          acc;
    logic [CW-1:0] cnt;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          valid;
    logic [1:0]    row;
    logic          done;
  } rec_t;
  logic clk = 0, reset = 1, start_i = 0, res_ready_i = 1;
  logic [KW-1:0] k_i = '0;
  logic busy_o, acc_clr_o, res_valid_o, done_o;
  logic [CW-1:0] feed_cnt_o;
  logic [N-1:0] a_feed_o, b_feed_o;
  logic [1:0] res_row_o;
  int checks = 0, failures = 0;
  bit mon_en = 0;
  rec_t exp_q[$];
  systolic_ctrl #(.ARRAY_SIZE(N), .K_WIDTH(KW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .k_i(k_i), .busy_o(busy_o),
    .acc_clr_o(acc_clr_o), .feed_cnt_o(feed_cnt_o), .a_feed_o(a_feed_o), .b_feed_o(b_feed_o),
    .res_valid_o(res_valid_o), .res_row_o(res_row_o), .res_ready_i(res_ready_i), .done_o(done_o)
  );
  always #5 clk = ~clk;
  function automatic rec_t cur();
    return '{busy_o, acc_clr_o, feed_cnt_o, a_feed_o, b_feed_o, res_valid_o, res_row_o, done_o};
  endfunction
  task automatic check(input string name, input rec_t got, input rec_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  // Expected trace of one run; stall_row is presented stall_n extra cycles.
  task automatic push_run(input int k, input int stall_row, input int stall_n);
    logic [N-1:0] k3_masks [6];
    rec_t r;
    k3_masks = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    r = '0; r.busy = 1; r.acc = 1; exp_q.push_back(r);
    for (int t = 0; t < k + N - 1; t++) begin
      r = '0; r.busy = 1; r.cnt = CW'(t);
      for (int l = 0; l < N; l++) r.a[l] = (t >= l) && (t < l + k);
      if (k == 3) r.a = k3_masks[t];
      r.b = r.a;
      exp_q.push_back(r);
    end
    r = '0; r.busy = 1;
    repeat (N) exp_q.push_back(r);
    for (int row = 0; row < N; row++) begin
      r = '0; r.busy = 1; r.valid = 1; r.row = 2'(row);
      repeat (row == stall_row ? stall_n + 1 : 1) exp_q.push_back(r);
    end
    r = '0; r.busy = 1; r.done = 1; exp_q.push_back(r);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic start(input int k);
    start_i = 1; k_i = KW'(k);
    cyc(1);
    start_i = 0; k_i = '0;
  endtask
  always @(negedge clk) if (mon_en && (cur() != '0)) begin
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_output got=%h want=0", cur());
    end else check("trace", cur(), exp_q.pop_front());
  end
  initial begin
    cyc(3);
    reset = 0;
    @(negedge clk); check("reset_state", cur(), '0);
    mon_en = 1;
    cyc(1);
    push_run(3, -1, 0); start(3); cyc(20);
    push_run(3, 1, 5); start(3); cyc(12);
    res_ready_i = 0; cyc(5); res_ready_i = 1; cyc(10);
    start(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("k0_ignored", cur(), '0);
    end
    cyc(1);
    push_run(3, -1, 0); start(3); cyc(3);
    start(5); cyc(20);
    push_run(3, -1, 0); start(3); cyc(4);
    reset = 1; cyc(1);
    exp_q.delete(); reset = 0;
    @(negedge clk); check("reset_mid", cur(), '0);
    cyc(1);
    push_run(3, -1, 0); start(3); cyc(20);
    push_run(255, -1, 0); start(255); cyc(280);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Sequencer for the ARRAY_SIZE x ARRAY_SIZE systolic grid of MAC processing elements.
- Runs one matrix product per start: clears the accumulators, then generates skewed feed enables for the A rows and B columns over K inner-dimension steps.
- Waits for the wavefront to drain, then hands the result rows out one per handshake.
- Sits between the A/B operand buffers, the PE grid and the result collector.

Parameters:
ARRAY_SIZE, 4, PE grid dimension N (rows = columns); must be >= 2
K_WIDTH, 8, width of the runtime inner dimension k_i; k max = 2^K_WIDTH-1
CNT_WIDTH, K_WIDTH+$clog2(ARRAY_SIZE)+1, feed/drain step counter width; must hold k+N-1 without wrap

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous active-high reset
start_i  input  1  start one product; sampled only in IDLE
k_i  input  K_WIDTH  inner dimension, latched on accepted start
busy_o  output  1  high from the cycle after an accepted start through the done_o cycle
acc_clr_o  output  1  one-cycle accumulator clear to all PEs
feed_cnt_o  output  CNT_WIDTH  feed step t; lane r reads operand index t-r
a_feed_o  output  ARRAY_SIZE  per-row A valid/read enable
b_feed_o  output  ARRAY_SIZE  per-column B valid/read enable, identical to a_feed_o
res_valid_o  output  1  result row available
res_row_o  output  $clog2(ARRAY_SIZE)  index of the presented result row
res_ready_i  input  1  collector accepts the row when res_valid_o && res_ready_i
done_o  output  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, applied at the clk edge while reset=1; overrides everything including mid-operation): state=IDLE; every output 0; latched k and counters 0.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> OUTPUT -> DONE -> IDLE.
- IDLE: start_i=1 && k_i!=0 -> latch k, go to CLEAR. start_i=1 with k_i=0 is ignored; stay in IDLE, no done_o.
- start_i in any non-IDLE state is ignored. k_i is not sampled outside an accepted start.
- CLEAR: 1 cycle, acc_clr_o=1; then FEED with t=0.
- FEED: k+N-1 cycles, t=0..k+N-2, feed_cnt_o=t. Mask bit r of a_feed_o/b_feed_o = (t>=r) && (t<r+k). After the last step go to DRAIN.
- DRAIN: exactly ARRAY_SIZE cycles; feed masks 0, feed_cnt_o holds 0. Then OUTPUT with row 0.
- OUTPUT: res_valid_o=1, res_row_o=current row. The row advances only on res_valid_o && res_ready_i. After the row N-1 handshake go to DONE.
- OUTPUT stall: res_ready_i low holds res_valid_o and res_row_o stable, with no timeout.
- DONE: done_o=1 for 1 cycle, busy_o still 1; then IDLE.
- busy_o=1 in CLEAR, FEED, DRAIN, OUTPUT and DONE.
- Outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- Counters never wrap: the CNT_WIDTH rule guarantees this for k max.

Optional Feature:
SYSTOLIC_CTRL_ABORT_EN
- Defined: adds input port abort_i (1 bit). abort_i=1 in any non-IDLE state forces IDLE at the next edge and clears all outputs, with no done_o. In IDLE, abort_i has priority over start_i (start dropped).
- Undefined: no abort_i port; the sequence always runs to DONE.

Test Plan:
- N=4, K_WIDTH=8, start_i with k_i=3 at cycle 0, res_ready_i=1 -> required response:
  - acc_clr_o at cycle 1.
  - FEED cycles 2..7 with feed_cnt_o 0..5 and a_feed_o = 0001, 0011, 0111, 1110, 1100, 1000.
  - DRAIN cycles 8..11 with masks 0.
  - res_row_o 0..3 at cycles 12..15.
  - done_o at cycle 16; busy_o=1 on cycles 1..16 only.
- Same run with res_ready_i low for 5 cycles while row 1 is presented -> res_row_o stays 1 and res_valid_o stays 1 throughout; done_o delayed 5 cycles to cycle 21.
- start_i with k_i=0 in IDLE -> busy_o, acc_clr_o and done_o all stay 0. start_i with k_i=5 asserted during FEED -> ignored; the current run completes with k=3 timing.
- reset=1 at cycle 5 of a k=3 run -> all outputs 0 at cycle 6. A new start at cycle 7 runs a clean full sequence (acc_clr_o at cycle 8).
- k_i=255, N=4 -> FEED lasts 258 cycles. feed_cnt_o reaches 257 with no wrap; final mask = 1000.
- ABORT_EN defined, abort_i=1 at cycle 9 (DRAIN) -> IDLE at cycle 10, all outputs 0, no done_o. ABORT_EN undefined -> port absent and the design compiles.
